// File: rtl/brc_pipe_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | brc_pipe_if : request/result bundle for the branch-compare pipeline     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface brc_pipe_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [TAGW-1:0] in_tag;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            br_less;
  logic            br_equal;
  logic            br_taken;
  logic            br_illegal;
  logic [TAGW-1:0] out_tag;
  logic [31:0]     cnt_cmp;
  logic [31:0]     cnt_taken;

  modport slave (
    input  in_valid, funct3, rs1_data, rs2_data, in_tag, flush, out_ready,
    output in_ready, out_valid, br_less, br_equal, br_taken, br_illegal,
           out_tag, cnt_cmp, cnt_taken
  );

  modport master (
    output in_valid, funct3, rs1_data, rs2_data, in_tag, flush, out_ready,
    input  in_ready, out_valid, br_less, br_equal, br_taken, br_illegal,
           out_tag, cnt_cmp, cnt_taken
  );
endinterface
`default_nettype wire

// File: rtl/brc_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | brc_pipe : pipelined RV32I branch comparator with valid/ready stages    |
// | Optional macro BRC_PIPE_PERF_EN enables the result counters. Rev 1.0    |
// +-------------------------------------------------------------------------+
module brc_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  brc_pipe_if.slave  io_bus
);

  localparam logic [2:0] c_BEQ  = 3'b000;
  localparam logic [2:0] c_BNE  = 3'b001;
  localparam logic [2:0] c_BLT  = 3'b100;
  localparam logic [2:0] c_BGE  = 3'b101;
  localparam logic [2:0] c_BLTU = 3'b110;
  localparam logic [2:0] c_BGEU = 3'b111;

  logic              w_eq;
  logic              w_less;
  logic              w_taken;
  logic              w_illegal;
  logic              w_accept;
  logic [STAGES:0]   w_ready;
  logic [STAGES-1:0] w_up_valid;
  logic [STAGES-1:0] w_up_less;
  logic [STAGES-1:0] w_up_equal;
  logic [STAGES-1:0] w_up_taken;
  logic [STAGES-1:0] w_up_illegal;
  logic [TAGW-1:0]   w_up_tag [STAGES];

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_less;
  logic [STAGES-1:0] r_equal;
  logic [STAGES-1:0] r_taken;
  logic [STAGES-1:0] r_illegal;
  logic [TAGW-1:0]   r_tag [STAGES];

  always_comb begin
    w_eq      = (io_bus.rs1_data == io_bus.rs2_data);
    w_less    = io_bus.funct3[1] ? (io_bus.rs1_data < io_bus.rs2_data)
                                 : ($signed(io_bus.rs1_data) < $signed(io_bus.rs2_data));
    w_illegal = 1'b0;
    case (io_bus.funct3)
      c_BEQ:          w_taken = w_eq;
      c_BNE:          w_taken = ~w_eq;
      c_BLT, c_BLTU:  w_taken = w_less;
      c_BGE, c_BGEU:  w_taken = ~w_less;
      default: begin
        w_taken   = 1'b0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Ready ripples backwards: a stage can take new data if empty or draining.
  always_comb begin
    w_ready[STAGES] = io_bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = ~r_valid[k] | w_ready[k+1];
    end
  end

  assign io_bus.in_ready = w_ready[0] & ~io_bus.flush;
  assign w_accept        = io_bus.in_valid & io_bus.in_ready;

  always_comb begin
    w_up_valid[0]   = w_accept;
    w_up_less[0]    = w_less;
    w_up_equal[0]   = w_eq;
    w_up_taken[0]   = w_taken;
    w_up_illegal[0] = w_illegal;
    w_up_tag[0]     = io_bus.in_tag;
    for (int k = 1; k < STAGES; k++) begin
      w_up_valid[k]   = r_valid[k-1];
      w_up_less[k]    = r_less[k-1];
      w_up_equal[k]   = r_equal[k-1];
      w_up_taken[k]   = r_taken[k-1];
      w_up_illegal[k] = r_illegal[k-1];
      w_up_tag[k]     = r_tag[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_less    <= '0;
      r_equal   <= '0;
      r_taken   <= '0;
      r_illegal <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (io_bus.flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_ready[k]) begin
          r_valid[k] <= w_up_valid[k];
          // Payload only moves with a valid entry so idle outputs stay quiet.
          if (w_up_valid[k]) begin
            r_less[k]    <= w_up_less[k];
            r_equal[k]   <= w_up_equal[k];
            r_taken[k]   <= w_up_taken[k];
            r_illegal[k] <= w_up_illegal[k];
            r_tag[k]     <= w_up_tag[k];
          end
        end
      end
    end
  end

  assign io_bus.out_valid  = r_valid[STAGES-1];
  assign io_bus.br_less    = r_less[STAGES-1];
  assign io_bus.br_equal   = r_equal[STAGES-1];
  assign io_bus.br_taken   = r_taken[STAGES-1];
  assign io_bus.br_illegal = r_illegal[STAGES-1];
  assign io_bus.out_tag    = r_tag[STAGES-1];

`ifdef BRC_PIPE_PERF_EN
  logic        w_out_fire;
  logic [31:0] r_cnt_cmp;
  logic [31:0] r_cnt_taken;

  assign w_out_fire = r_valid[STAGES-1] & io_bus.out_ready & ~io_bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_cmp   <= 32'd0;
      r_cnt_taken <= 32'd0;
    end else if (w_out_fire) begin
      r_cnt_cmp <= r_cnt_cmp + 32'd1;
      if (r_taken[STAGES-1]) begin
        r_cnt_taken <= r_cnt_taken + 32'd1;
      end
    end
  end

  assign io_bus.cnt_cmp   = r_cnt_cmp;
  assign io_bus.cnt_taken = r_cnt_taken;
`else
  assign io_bus.cnt_cmp   = 32'd0;
  assign io_bus.cnt_taken = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_brc_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_brc_pipe : self-checking bench for brc_pipe (XLEN=32, STAGES=2)      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_brc_pipe;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        less;
    logic        eq;
    logic        taken;
    logic        ill;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  brc_pipe_if #(.XLEN(32), .TAGW(5)) bus ();

  brc_pipe #(.XLEN(32), .STAGES(2), .TAGW(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  logic or_manual = 1'b1;
  logic bp_rand   = 1'b0;
  logic rnd_bit   = 1'b1;
  assign bus.out_ready = bp_rand ? rnd_bit : or_manual;

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  int          n_vec = 0;
  int          n_err = 0;
  longint      cyc   = 0;
  vec_t        q[$];
  vec_t        m_exp;
  logic [31:0] m_cmp   = 32'd0;
  logic [31:0] m_taken = 32'd0;
  vec_t        tbl[13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_cmp"},   {32'd0, bus.cnt_cmp},   {32'd0, m_cmp});
    chk({nm, "_taken"}, {32'd0, bus.cnt_taken}, {32'd0, m_taken});
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] tag, input logic less, input logic eq,
                              input logic taken, input logic ill);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.tag = tag;
    v.less = less; v.eq = eq; v.taken = taken; v.ill = ill;
    return v;
  endfunction

  // Signed order is unsigned order with the sign bits flipped.
  function automatic vec_t model(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] tag);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.tag = tag;
    v.eq   = (a == b);
    v.less = f3[1] ? (a < b) : ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
    case (f3)
      3'b000:         v.taken = v.eq;
      3'b001:         v.taken = !v.eq;
      3'b100, 3'b110: v.taken = v.less;
      3'b101, 3'b111: v.taken = !v.less;
      default:        v.taken = 1'b0;
    endcase
    v.ill = (f3 == 3'b010) || (f3 == 3'b011);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_out: got result tag %0d, expected no result", bus.out_tag);
      end else begin
        m_exp = q.pop_front();
        chk($sformatf("result_tag%0d{tag,less,eq,taken,ill}", m_exp.tag),
            {55'd0, bus.out_tag, bus.br_less, bus.br_equal, bus.br_taken, bus.br_illegal},
            {55'd0, m_exp.tag, m_exp.less, m_exp.eq, m_exp.taken, m_exp.ill});
`ifdef BRC_PIPE_PERF_EN
        m_cmp = m_cmp + 32'd1;
        if (m_exp.taken) m_taken = m_taken + 32'd1;
`endif
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.funct3   = v.f3;
    bus.rs1_data = v.a;
    bus.rs2_data = v.b;
    bus.in_tag   = v.tag;
  endtask

  // Entered and left at posedge+1; returns after the accepting edge.
  task automatic send(input vec_t v);
    bit done = 1'b0;
    drive(v);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(v);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for tag %0d, expected acceptance", v.tag);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    int     acc;
    int     idx;
    vec_t   v;

    bus.in_valid = 1'b0;
    bus.funct3   = 3'b000;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.in_tag   = '0;
    bus.flush    = 1'b0;

    tbl[0]  = mk(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3,  1, 0, 1, 0);
    tbl[1]  = mk(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1,  0, 0, 0, 0);
    tbl[2]  = mk(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2,  0, 0, 1, 0);
    tbl[3]  = mk(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd4,  0, 1, 1, 0);
    tbl[4]  = mk(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5,  0, 1, 0, 0);
    tbl[5]  = mk(3'b010, 32'h0000_0005, 32'h0000_0007, 5'd6,  1, 0, 0, 1);
    tbl[6]  = mk(3'b011, 32'h0000_0007, 32'h0000_0007, 5'd7,  0, 1, 0, 1);
    tbl[7]  = mk(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 5'd8,  1, 0, 0, 0);
    tbl[8]  = mk(3'b110, 32'h0000_0000, 32'hFFFF_FFFF, 5'd9,  1, 0, 1, 0);
    tbl[9]  = mk(3'b101, 32'h0000_0005, 32'h0000_0005, 5'd10, 0, 1, 1, 0);
    tbl[10] = mk(3'b001, 32'h0000_0001, 32'h0000_0002, 5'd11, 1, 0, 1, 0);
    tbl[11] = mk(3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 5'd12, 0, 0, 0, 1);
    tbl[12] = mk(3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 5'd13, 0, 0, 0, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_flags", {59'd0, bus.out_valid, bus.br_less, bus.br_equal, bus.br_taken, bus.br_illegal}, 64'd0);
    chk("rst_tag", {59'd0, bus.out_tag}, 64'd0);
    chk("rst_counters", {bus.cnt_cmp, bus.cnt_taken}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

    // Two-cycle latency for a lone BLT
    send(tbl[0]);
    @(negedge clk);
    chk("latency_edge_n", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_edge_n1", {63'd0, bus.out_valid}, 64'd1);
    drain();

    t0 = cyc;
    for (int i = 1; i < 13; i++) send(tbl[i]);
    chk("throughput_cycles", 64'(cyc - t0), 64'd12);
    drain();
    chk_cnt("cnt_after_table");

    // Backpressure: four requests offered with out_ready low
    or_manual = 1'b0;
    acc = 0;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      v = model(3'b000, 32'(idx), 32'(idx), 5'(20 + idx));
      drive(v);
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(v);
        acc++;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_hold_tag", {59'd0, bus.out_tag}, 64'd20);
    end
    @(posedge clk);
    #1 or_manual = 1'b1;
    drain();

    // Flush with a full pipeline and a live output handshake
    or_manual = 1'b0;
    send(model(3'b000, 32'd1, 32'd1, 5'd30));
    send(model(3'b000, 32'd2, 32'd2, 5'd31));
    @(negedge clk);
    chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    drive(model(3'b000, 32'd3, 32'd3, 5'd29));
    or_manual = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk_cnt("cnt_after_flush");
    repeat (2) @(negedge clk);
    chk("flush_stays_empty", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Random traffic under random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      send(model(3'($urandom_range(0, 7)), a, b, 5'(i)));
    end
    bp_rand   = 1'b0;
    or_manual = 1'b1;
    drain();
    chk_cnt("cnt_after_random");

    // Asynchronous reset while results are in flight
    send(model(3'b000, 32'd9, 32'd9, 5'd7));
    send(model(3'b000, 32'd9, 32'd9, 5'd8));
    send(model(3'b000, 32'd9, 32'd9, 5'd9));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flags", {59'd0, bus.out_valid, bus.br_less, bus.br_equal, bus.br_taken, bus.br_illegal}, 64'd0);
    chk("midrst_tag", {59'd0, bus.out_tag}, 64'd0);
    chk("midrst_counters", {bus.cnt_cmp, bus.cnt_taken}, 64'd0);
    q.delete();
    m_cmp   = 32'd0;
    m_taken = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_midrst", {63'd0, bus.in_ready}, 64'd1);

`ifdef BRC_PIPE_PERF_EN
    for (int i = 0; i < 10; i++)
      send(model((i < 6) ? 3'b000 : 3'b001, 32'd5, 32'd5, 5'(i)));
    drain();
    chk("perf_cnt_cmp_10", {32'd0, bus.cnt_cmp}, 64'd10);
    chk("perf_cnt_taken_6", {32'd0, bus.cnt_taken}, 64'd6);
    @(negedge clk);
    dut.r_cnt_cmp   = 32'hFFFF_FFFF;
    dut.r_cnt_taken = 32'hFFFF_FFFF;
    m_cmp   = 32'hFFFF_FFFF;
    m_taken = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    send(model(3'b000, 32'd1, 32'd1, 5'd15));
    drain();
    chk("perf_wrap_cmp", {32'd0, bus.cnt_cmp}, 64'd0);
    chk("perf_wrap_taken", {32'd0, bus.cnt_taken}, 64'd0);
    chk_cnt("cnt_after_wrap");
`else
    for (int i = 0; i < 3; i++) send(model(3'b000, 32'd4, 32'd4, 5'(i)));
    drain();
    chk("perf_off_cnt_cmp", {32'd0, bus.cnt_cmp}, 64'd0);
    chk("perf_off_cnt_taken", {32'd0, bus.cnt_taken}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
